// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the RV32I multi-cycle controller and its datapath
// master = controller (consumes instr/flags/ready, drives strobes and mux selects), slave = datapath
interface multicycle_ctrl_if #(parameter int STATE_W = 4);
    logic [31:0]        instr;
    logic               zero;
    logic               imem_ready;
    logic               dmem_ready;
    logic               ir_write;
    logic               pc_write;
    logic               adr_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [2:0]         ImmSrc;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_ctrl;
    logic [1:0]         result_src;
    logic               illegal;
    logic [STATE_W-1:0] state_o;
    modport master (
        input  instr, zero, imem_ready, dmem_ready,
        output ir_write, pc_write, adr_src, mem_read, mem_write, reg_write,
        output ImmSrc, alu_src_a, alu_src_b, alu_ctrl, result_src, illegal, state_o
    );
    modport slave (
        output instr, zero, imem_ready, dmem_ready,
        input  ir_write, pc_write, adr_src, mem_read, mem_write, reg_write,
        input  ImmSrc, alu_src_a, alu_src_b, alu_ctrl, result_src, illegal, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM sequencing fetch/decode/execute/memory/writeback
// clk, rst (sync, active-high); bus.master carries instr/zero/imem_ready/dmem_ready in and
// ir_write/pc_write/adr_src/mem_read/mem_write/reg_write/ImmSrc/alu_src_a/alu_src_b/alu_ctrl/
// result_src/illegal/state_o out
module multicycle_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int STATE_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, LUI, TRAP
    } state_t;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    state_t state, state_nx, dec_nx, bad;
    logic [6:0] op;
    logic [2:0] f3, imm_dec;
    assign op = bus.instr[6:0];
    assign f3 = bus.instr[14:12];
    assign bad = ILLEGAL_TRAP ? TRAP : FETCH;
    assign imm_dec = op == OP_ST  ? 3'b010 :
                     op == OP_BR  ? 3'b011 :
                     op == OP_JAL ? 3'b100 :
                     op == OP_LUI ? 3'b001 : 3'b000;
    // funct3 011 (sltu) has no ALU op here, and only beq/bne are supported
    assign dec_nx = (op == OP_LD || op == OP_ST)      ? MEMADR :
                    (op == OP_R && f3 != 3'b011)      ? EXECR  :
                    (op == OP_I && f3 != 3'b011)      ? EXECI  :
                    (op == OP_BR && f3[2:1] == 2'b00) ? BRANCH :
                    op == OP_JAL                      ? JAL    :
                    op == OP_JALR                     ? JALR   :
                    op == OP_LUI                      ? LUI    : bad;
    function automatic logic [2:0] alu_op(input logic [2:0] f, input logic sub);
        return f == 3'b000 ? {2'b00, sub} :
               f == 3'b111 ? 3'b010 :
               f == 3'b110 ? 3'b011 :
               f == 3'b100 ? 3'b100 :
               f == 3'b010 ? 3'b101 :
               f == 3'b001 ? 3'b110 :
               f == 3'b101 ? 3'b111 : 3'b000;
    endfunction
    always_ff @(posedge clk) begin
        state <= rst ? FETCH : state_nx;
    end
    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:   state_nx = bus.imem_ready ? DECODE : FETCH;
            DECODE:  state_nx = dec_nx;
            MEMADR:  state_nx = op == OP_ST ? MEMWR : MEMRD;
            MEMRD:   state_nx = bus.dmem_ready ? MEMWB : MEMRD;
            MEMWR:   state_nx = bus.dmem_ready ? FETCH : MEMWR;
            EXECR:   state_nx = ALUWB;
            EXECI:   state_nx = ALUWB;
            JALR:    state_nx = JAL;
            JAL:     state_nx = ALUWB;
            LUI:     state_nx = ALUWB;
            TRAP:    state_nx = TRAP;
            default: state_nx = FETCH;
        endcase
    end
    // reset forces every output to its idle default so no write can land in the reset cycle
    always_comb begin
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.ImmSrc     = 3'b000;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_ctrl   = 3'b000;
        bus.result_src = 2'b00;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.ImmSrc = (state == FETCH || state == TRAP) ? 3'b000 : imm_dec;
            case (state)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_write   = 1'b1;
                        bus.pc_write   = 1'b1;
                        bus.alu_src_b  = 2'b10;
                        bus.result_src = 2'b10;
                    end
                end
                DECODE: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b01;
                end
                MEMADR, JALR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                end
                MEMRD: begin
                    bus.adr_src  = 1'b1;
                    bus.mem_read = 1'b1;
                end
                MEMWB: begin
                    bus.result_src = 2'b01;
                    bus.reg_write  = 1'b1;
                end
                MEMWR: begin
                    bus.adr_src   = 1'b1;
                    bus.mem_write = 1'b1;
                end
                EXECR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_ctrl  = alu_op(f3, bus.instr[30]);
                end
                EXECI: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                    bus.alu_ctrl  = alu_op(f3, 1'b0);
                end
                ALUWB: bus.reg_write = 1'b1;
                BRANCH: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_ctrl  = 3'b001;
                    bus.pc_write  = bus.zero ^ f3[0];
                end
                JAL: begin
                    bus.pc_write  = 1'b1;
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                end
                LUI: begin
                    bus.alu_src_a = 2'b11;
                    bus.alu_src_b = 2'b01;
                end
                TRAP: bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end
    assign bus.state_o = STATE_W'(state);
endmodule
